// File: rtl/hlsm_launcher.sv
// ---------------------------------------------------------------------------
// hlsm_launcher
//
// Handshake front-end for an HLSM datapath block with a Start/Done interface.
// It accepts one operand bundle at a time and holds the operands stable on the
// HLSM inputs. It then pulses Start for one cycle and waits for Done. When
// Done arrives it captures the two results and offers them downstream on a
// valid/ready channel. It also records the Start-to-Done latency, counts
// completed jobs, and raises sticky flags for timeouts and for Done pulses
// that arrive outside WAIT.
//
// Ports:
//   Clk, Rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand bundle handshake
//   in_a..in_g          operand bundle
//   a..g                registered operands driven to the HLSM
//   Start               one-cycle launch pulse (registered)
//   Done, j, l          HLSM completion pulse and results (valid with Done)
//   out_valid/out_ready result handshake
//   out_j, out_l        captured results
//   lat_meas            Start-to-Done cycle count of the last completed job
//   job_count           completed jobs (wraps)
//   timeout_err         sticky: a job timed out
//   spurious_done       sticky: Done seen outside WAIT
// ---------------------------------------------------------------------------
module hlsm_launcher #(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_c,
  input  logic [DATA_WIDTH-1:0] in_d,
  input  logic [DATA_WIDTH-1:0] in_e,
  input  logic [DATA_WIDTH-1:0] in_f,
  input  logic [DATA_WIDTH-1:0] in_g,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] c,
  output logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] e,
  output logic [DATA_WIDTH-1:0] f,
  output logic [DATA_WIDTH-1:0] g,
  output logic                  Start,
  input  logic                  Done,
  input  logic [DATA_WIDTH-1:0] j,
  input  logic [DATA_WIDTH-1:0] l,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_j,
  output logic [DATA_WIDTH-1:0] out_l,
  output logic [7:0]            lat_meas,
  output logic [15:0]           job_count,
  output logic                  timeout_err,
  output logic                  spurious_done
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt;
  logic       accept;
  logic       capture;
  logic       expire;

  // Both handshake outputs come straight from the state so neither channel
  // has a combinational path from the other side's valid/ready.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the single-cycle strobes that steer the datapath.
  // In WAIT, Done is tested before the timeout, so a Done that arrives on the
  // last allowed cycle still produces a result.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (Done) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt == TIMEOUT_CNT) begin
          expire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers. Start is registered from the accept strobe, so it is
  // high exactly during the LAUNCH cycle. The operands only load on accept,
  // so the free-running HLSM sees stable inputs for the whole job.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      a             <= '0;
      b             <= '0;
      c             <= '0;
      d             <= '0;
      e             <= '0;
      f             <= '0;
      g             <= '0;
      Start         <= 1'b0;
      cnt           <= '0;
      out_j         <= '0;
      out_l         <= '0;
      lat_meas      <= '0;
      job_count     <= '0;
      timeout_err   <= 1'b0;
      spurious_done <= 1'b0;
    end else begin
      Start <= accept;

      if (accept) begin
        a <= in_a;
        b <= in_b;
        c <= in_c;
        d <= in_d;
        e <= in_e;
        f <= in_f;
        g <= in_g;
      end

      // cnt is 1 in the first WAIT cycle, so it equals the number of cycles
      // elapsed since the Start cycle.
      if (state_q == ST_LAUNCH) begin
        cnt <= 8'd1;
      end else if (state_q == ST_WAIT && !capture && !expire) begin
        cnt <= cnt + 8'd1;
      end

      if (capture) begin
        out_j     <= j;
        out_l     <= l;
        lat_meas  <= cnt;
        job_count <= job_count + 16'd1;
      end

      if (expire) begin
        timeout_err <= 1'b1;
      end

      if (Done && state_q != ST_WAIT) begin
        spurious_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hlsm_launcher.sv
// ---------------------------------------------------------------------------
// tb_hlsm_launcher
//
// Self-checking bench for hlsm_launcher. A small behavioural HLSM model
// returns Done a programmable number of cycles after Start, with
// j = a+b+c+d and l = e*f*g truncated to 16 bits. A vector table drives the
// single-job cases. Hand-written sequences cover back-to-back jobs, output
// backpressure, the spurious-Done and timeout-boundary cases, a real timeout
// and a reset in the middle of WAIT.
// ---------------------------------------------------------------------------
module tb_hlsm_launcher;

  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a, in_b, in_c, in_d, in_e, in_f, in_g;
  logic [DW-1:0] a, b, c, d, e, f, g;
  logic          Start;
  logic          Done;
  logic [DW-1:0] j, l;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_j, out_l;
  logic [7:0]    lat_meas;
  logic [15:0]   job_count;
  logic          timeout_err;
  logic          spurious_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] a, b, c, d, e, f, g;
    int            lat;
    logic [DW-1:0] exp_j;
    logic [DW-1:0] exp_l;
  } vec_t;

  vec_t vecs[5];

  // HLSM model state
  int   model_lat = 5;
  bit   model_en  = 1'b1;
  logic manual_done = 1'b0;
  int   rem = 0;
  int   exp_jobs = 0;

  hlsm_launcher #(.DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .in_e(in_e), .in_f(in_f), .in_g(in_g),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .Start(Start), .Done(Done), .j(j), .l(l),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_j(out_j), .out_l(out_l),
    .lat_meas(lat_meas), .job_count(job_count),
    .timeout_err(timeout_err), .spurious_done(spurious_done)
  );

  always #5 Clk = ~Clk;

  // Behavioural HLSM: Done is high exactly model_lat cycles after the Start
  // cycle. It ignores the launcher reset so that a Done can arrive late.
  always @(posedge Clk) begin
    if (Start && model_en) rem <= model_lat;
    else if (rem > 0)      rem <= rem - 1;
  end

  assign Done = (model_en && rem == 1) || manual_done;
  assign j    = a + b + c + d;
  assign l    = e * f * g;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents a bundle at a negedge with the launcher idle. Returns at the
  // negedge of the LAUNCH cycle, after checking Start and the held operands.
  task automatic applyStimulus(input vec_t v);
    model_lat = v.lat;
    in_a = v.a; in_b = v.b; in_c = v.c; in_d = v.d;
    in_e = v.e; in_f = v.f; in_g = v.g;
    in_valid = 1'b1;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    @(negedge Clk);
    in_valid = 1'b0;
    checkOutput("start_launch", 32'(Start), 32'd1);
    checkOutput("a_held", 32'(a), 32'(v.a));
    checkOutput("g_held", 32'(g), 32'(v.g));
  endtask

  // Full job with out_ready high. out_valid should appear L+1 negedges after
  // the LAUNCH negedge (Done in cycle LAUNCH+L, HOLD in the following cycle).
  task automatic runJob(input vec_t v);
    int waited;
    int extra;
    waited = 0;
    extra  = 0;
    out_ready = 1'b1;
    applyStimulus(v);
    while (!out_valid && waited < 40) begin
      @(negedge Clk);
      waited++;
      if (Start) extra++;
    end
    exp_jobs++;
    checkOutput("hold_delay", 32'(waited), 32'(v.lat + 1));
    checkOutput("extra_start", 32'(extra), 32'd0);
    checkOutput("out_j", 32'(out_j), 32'(v.exp_j));
    checkOutput("out_l", 32'(out_l), 32'(v.exp_l));
    checkOutput("lat_meas", 32'(lat_meas), 32'(v.lat));
    checkOutput("job_count", 32'(job_count), 32'(exp_jobs));
    @(negedge Clk);
    checkOutput("back_idle_valid", 32'(out_valid), 32'd0);
    checkOutput("back_idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    int nstart;
    int nres;
    int start_cyc[3];
    logic [DW-1:0] res_j[3];
    logic [DW-1:0] res_l[3];
    bit seen_valid;
    vec_t vb;

    // a..g, latency, expected j, expected l
    vecs[0] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 5, 16'd10, 16'd210};
    vecs[1] = '{16'hFF9C, 16'd50, 16'd25, 16'd25, 16'hFFFD, 16'd4, 16'd2, 5, 16'h0000, 16'hFFE8};
    vecs[2] = '{16'h7FFF, 16'd1, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3, 16'h8000, 16'hFFFF};
    vecs[3] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1, 16'd0, 16'd0};
    vecs[4] = '{16'd1000, 16'd2000, 16'd3000, 16'hE890, 16'd100, 16'd100, 16'd10, 7, 16'h0000, 16'h86A0};

    Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0; in_f = '0; in_g = '0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;

    // Reset state
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_start", 32'(Start), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_a", 32'(a), 32'd0);
    checkOutput("rst_out_j", 32'(out_j), 32'd0);
    checkOutput("rst_lat", 32'(lat_meas), 32'd0);
    checkOutput("rst_jobs", 32'(job_count), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst_spurious", 32'(spurious_done), 32'd0);
    @(negedge Clk);

    // Table-driven single jobs
    for (int i = 0; i < 5; i++) runJob(vecs[i]);

    // Back-to-back: in_valid held, bundles 0,1,0, latency 5
    model_lat = 5;
    out_ready = 1'b1;
    in_a = vecs[0].a; in_b = vecs[0].b; in_c = vecs[0].c; in_d = vecs[0].d;
    in_e = vecs[0].e; in_f = vecs[0].f; in_g = vecs[0].g;
    in_valid = 1'b1;
    nstart = 0; nres = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (Start) begin
        if (nstart < 3) start_cyc[nstart] = k;
        nstart++;
        if (nstart == 1) begin
          in_a = vecs[1].a; in_b = vecs[1].b; in_c = vecs[1].c; in_d = vecs[1].d;
          in_e = vecs[1].e; in_f = vecs[1].f; in_g = vecs[1].g;
        end else if (nstart == 2) begin
          in_a = vecs[0].a; in_b = vecs[0].b; in_c = vecs[0].c; in_d = vecs[0].d;
          in_e = vecs[0].e; in_f = vecs[0].f; in_g = vecs[0].g;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (nres < 3) begin
          res_j[nres] = out_j;
          res_l[nres] = out_l;
        end
        nres++;
      end
    end
    exp_jobs += 3;
    checkOutput("b2b_starts", 32'(nstart), 32'd3);
    checkOutput("b2b_results", 32'(nres), 32'd3);
    if (nstart >= 3) begin
      checkOutput("b2b_gap1", 32'(start_cyc[1] - start_cyc[0]), 32'd8);
      checkOutput("b2b_gap2", 32'(start_cyc[2] - start_cyc[1]), 32'd8);
    end
    if (nres >= 3) begin
      checkOutput("b2b_j0", 32'(res_j[0]), 32'd10);
      checkOutput("b2b_j1", 32'(res_j[1]), 32'd0);
      checkOutput("b2b_l1", 32'(res_l[1]), 32'h0000FFE8);
      checkOutput("b2b_l2", 32'(res_l[2]), 32'd210);
    end
    checkOutput("b2b_jobs", 32'(job_count), 32'(exp_jobs));

    // Output backpressure: hold for 10 cycles with a new bundle waiting
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge Clk);
      cyc++;
    end
    exp_jobs++;
    in_a = vecs[1].a; in_b = vecs[1].b; in_c = vecs[1].c; in_d = vecs[1].d;
    in_e = vecs[1].e; in_f = vecs[1].f; in_g = vecs[1].g;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_j", 32'(out_j), 32'd10);
      checkOutput("bp_out_l", 32'(out_l), 32'd210);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_start", 32'(Start), 32'd0);
      @(negedge Clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge Clk);
    checkOutput("bp_release", 32'(in_ready), 32'd1);
    checkOutput("bp_jobs", 32'(job_count), 32'(exp_jobs));

    // Spurious Done in IDLE
    manual_done = 1'b1;
    @(negedge Clk);
    manual_done = 1'b0;
    checkOutput("spur_flag", 32'(spurious_done), 32'd1);
    checkOutput("spur_still_idle", 32'(in_ready), 32'd1);
    checkOutput("spur_no_start", 32'(Start), 32'd0);

    // Done exactly at cnt==TIMEOUT: result wins, no timeout
    vb = vecs[4];
    vb.lat = 16;
    runJob(vb);
    checkOutput("edge_timeout_clear", 32'(timeout_err), 32'd0);

    // Real timeout: model stays silent. cnt reaches 16 in cycle Start+16; the
    // flag is visible from the next cycle, with the launcher back in IDLE.
    model_en = 1'b0;
    out_ready = 1'b1;
    applyStimulus(vecs[0]);
    cyc = 0;
    seen_valid = 1'b0;
    while (!timeout_err && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("to_cycles", 32'(cyc), 32'd17);
    checkOutput("to_idle", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(negedge Clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("to_no_valid", 32'(seen_valid), 32'd0);
    checkOutput("to_jobs", 32'(job_count), 32'(exp_jobs));
    checkOutput("to_sticky", 32'(timeout_err), 32'd1);
    model_en = 1'b1;

    // Reset in WAIT at cnt==3; Done (latency 8) arrives after reset
    applyStimulus(vecs[1]);
    vb = vecs[1];
    model_lat = 8;
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checkOutput("mr_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mr_a", 32'(a), 32'd0);
    checkOutput("mr_jobs", 32'(job_count), 32'd0);
    checkOutput("mr_timeout", 32'(timeout_err), 32'd0);
    checkOutput("mr_spurious_clr", 32'(spurious_done), 32'd0);
    seen_valid = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("mr_spurious_set", 32'(spurious_done), 32'd1);
    checkOutput("mr_no_result", 32'(seen_valid), 32'd0);
    checkOutput("mr_out_j", 32'(out_j), 32'd0);
    checkOutput("mr_lat", 32'(lat_meas), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hlsm_launcher.md
# hlsm_launcher

Handshake front-end that sits directly upstream of an HLSM datapath block (Start/Done interface, seven signed operands a..g, two signed results j/l). Accepts one operand bundle at a time on a valid/ready input channel, holds the operands stable on the HLSM inputs, pulses Start for one cycle, and waits for Done. It then captures j/l and presents them on a valid/ready output channel. It also measures Start-to-Done latency and flags timeouts and spurious Done pulses for the test benches.

## Interface
- DATA_WIDTH, 16, width of every operand and result (signed, two's complement)
- TIMEOUT, 16, max cycles after Start to wait for Done; must be > HLSM latency and ≤ 255
- Clk  in  1  clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  launcher can accept a bundle
- in_a..in_g  in  DATA_WIDTH each  operand bundle (seven ports)
- a..g  out  DATA_WIDTH each  registered operands driven to the HLSM
- Start  out  1  one-cycle launch pulse to the HLSM
- Done  in  1  completion pulse from the HLSM
- j, l  in  DATA_WIDTH each  HLSM results, valid in the Done cycle
- out_valid  out  1  captured result available
- out_ready  in  1  consumer accepts the result
- out_j, out_l  out  DATA_WIDTH each  captured results
- lat_meas  out  8  Start-to-Done cycle count of the last completed job
- job_count  out  16  completed jobs; wraps 0xFFFF -> 0
- timeout_err  out  1  sticky: a job timed out
- spurious_done  out  1  sticky: Done seen outside WAIT

## Operation
- States: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: register in_a..in_g into a..g and go to LAUNCH.
- LAUNCH:
  - Start=1 for exactly this cycle.
  - cnt<=1.
  - Go to WAIT.
- WAIT:
  - If Done=1: out_j<=j, out_l<=l, lat_meas<=cnt, job_count<=job_count+1, go to HOLD.
  - Else if cnt==TIMEOUT: timeout_err<=1, go to IDLE with no result.
  - Else cnt<=cnt+1.
- HOLD:
  - out_valid=1.
  - On out_ready: go to IDLE.
- a..g remain unchanged from capture until the next accepted bundle. They are stable through LAUNCH, WAIT and HOLD, because the HLSM datapath is free-running and samples its inputs every cycle.
- Done while in IDLE, LAUNCH or HOLD: set spurious_done, ignore the pulse, no state change.
- Done in the same cycle cnt==TIMEOUT: Done wins and the result is captured; timeout_err is not set.
- Sticky flags clear only on Rst.
- Results are passed through bit-exact; the launcher performs no arithmetic on data.

## Timing
- Reset values:
  - State IDLE.
  - Start=0, out_valid=0, a..g=0, out_j=0, out_l=0, lat_meas=0, job_count=0, timeout_err=0, spurious_done=0, cnt=0.
  - in_ready=1 in the cycle after reset.
- in_ready and out_valid are decoded from state, not combinationally from in_valid or out_ready.
- Start is registered.
- Operand bundle accepted at edge t:
  - a..g change at t.
  - Start is high during cycle t+1 (LAUNCH).
- HLSM Done is sampled L cycles after the Start cycle, so lat_meas=L.
- out_valid rises the cycle after Done is sampled. out_j/out_l are stable while out_valid=1.
- Back-to-back throughput is one job per L+3 cycles minimum: accept, LAUNCH, L WAIT cycles, HOLD with out_ready=1.
- Rst asserted mid-job (any state): return to IDLE next edge with all reset values. A Done arriving after reset is then flagged as spurious_done.
- Only one job is outstanding at any time; no new Start is issued until HOLD completes or a timeout occurs.

## Test plan
1. Single job:
   - Stimulus: a=1, b=2, c=3, d=4, e=5, f=6, g=7 with an HLSM model of latency 5 (j=a+b+c+d, l=e*f*g).
   - Response: one Start pulse, out_j=10, out_l=210, lat_meas=5, job_count=1.
2. Back-to-back:
   - Stimulus: three bundles with in_valid held high and out_ready=1, second bundle a=-100, b=50, c=25, d=25, e=-3, f=4, g=2.
   - Response: out_j=0, out_l=-24, job_count=3, exactly three Start pulses, each spaced 8 cycles apart.
3. Output backpressure:
   - Stimulus: out_ready=0 for 10 cycles after out_valid rises.
   - Response: out_j/out_l held stable, in_ready=0 throughout, no new Start.
4. Timeout:
   - Stimulus: model never returns Done, TIMEOUT=16.
   - Response: timeout_err=1 exactly 16 cycles after Start, state returns to IDLE, out_valid never rises, job_count unchanged.
5. Spurious Done and boundary:
   - Stimulus: Done pulsed in IDLE; in a later job, Done arrives at cnt==TIMEOUT.
   - Response: spurious_done=1 after the IDLE pulse; the late result is captured with lat_meas=16 and timeout_err=0.
6. Reset mid-WAIT:
   - Stimulus: Rst asserted at cnt=3, then Done arrives.
   - Response: all outputs at reset values, spurious_done=1, no result is emitted.
